cu_line_buffer: RTL and testbench
=================================

Name: cu_line_buffer

Overview:
- Upstream feeder for cu_engine, the 3x3 streaming convolution engine.
- Accepts a raster-order 8-bit pixel stream for one frame and stores the two previous rows in internal line memories.
- Each accepted pixel produces a registered 3-pixel vertical column (data_in for cu_engine) and the matching 9-bit PE enable ramp (pe_en_ctrl).
- Marks full 3x3 windows and end of frame.

Parameters:
- DATA_W, 8, pixel width; column output width is 3*DATA_W.
- IMG_W, 8, pixels per row, must be >= 3.
- IMG_H, 8, rows per frame, must be >= 3.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sof  input  1  start of frame; qualified by pix_valid; marks the pixel at row 0, col 0.
- pix_valid  input  1  pix_in valid this cycle. The block is always ready; there is no backpressure.
- pix_in  input  DATA_W  pixel value.
- col_out  output  3*DATA_W  bits [7:0] = row r-2, [15:8] = row r-1, [23:16] = row r, all at the current column; drives cu_engine data_in.
- pe_en_ctrl  output  9  PE enable mask; drives cu_engine pe_en_ctrl.
- col_valid  output  1  col_out and pe_en_ctrl are meaningful this cycle (row >= 2).
- win_valid  output  1  a complete 3x3 window is present in the engine (row >= 2 and col >= 2).
- busy  output  1  state is not IDLE.
- frame_done  output  1  one-cycle pulse, coincident with the outputs of the last pixel.

Behaviour:
- Reset, and every cycle while rst = 1:
  - state = IDLE, row and col counters = 0.
  - col_out = 0, pe_en_ctrl = 0, col_valid = 0, win_valid = 0, busy = 0, frame_done = 0.
  - Line memories are not cleared.
- States and transitions:
  - IDLE -> FILL on sof & pix_valid. That pixel is accepted as row 0, col 0.
  - FILL covers rows 0-1. FILL -> RUN on the pixel accepted at row 1, col IMG_W-1.
  - RUN covers rows 2..IMG_H-1. RUN -> IDLE on the pixel accepted at row IMG_H-1, col IMG_W-1.
  - In IDLE, pix_valid without sof is ignored. sof without pix_valid is ignored in every state.
- Accept (pix_valid = 1 in FILL or RUN, or the starting pixel in IDLE):
  - Read lb1[col] (row r-1) and lb2[col] (row r-2).
  - Write lb2[col] <= lb1[col] and lb1[col] <= pix_in in the same edge (read-before-write).
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
- Latency: outputs are registered and appear exactly 1 cycle after the accepting edge.
- Output for an accepted pixel at (r, c) with r >= 2:
  - col_out = {pix_in, lb1[c], lb2[c]}, col_valid = 1.
  - pe_en_ctrl = 9'h007 for c = 0, 9'h03F for c = 1, 9'h1FF for c >= 2.
  - win_valid = 1 only when c >= 2.
- Output for an accepted pixel with r < 2:
  - col_out is updated with the same packing (its contents are don't-care).
  - pe_en_ctrl = 0, col_valid = 0, win_valid = 0.
- Stall (pix_valid = 0 in FILL or RUN):
  - col_out holds its value, counters hold.
  - pe_en_ctrl = 0, col_valid = 0, win_valid = 0, so the engine does not advance.
- frame_done = 1 for one cycle together with the output of pixel (IMG_H-1, IMG_W-1). busy falls in the same cycle.
- sof & pix_valid while in FILL or RUN aborts the current frame:
  - counters restart; that pixel becomes (0, 0); state = FILL.
  - No frame_done is issued for the aborted frame.
- A frame may start in the cycle immediately after frame_done; there are no bubble requirements.
- rst asserted mid-frame returns to IDLE on the next edge. The next frame is clean because FILL rewrites both line memories before col_valid can assert.

Test Plan:
- Setup: IMG_W = 4, IMG_H = 4, continuous pix_valid, sof on the first pixel, pixel(r, c) = 4r + c.
- Rows 0-1 -> col_valid, win_valid and pe_en_ctrl are 0 for 8 cycles; busy = 1 from 1 cycle after sof.
- Row 2 -> col_out = 24'h080400 with pe_en_ctrl = 9'h007, then 24'h090501 with 9'h03F, then 24'h0A0602 with 9'h1FF and win_valid = 1, then 24'h0B0703 with 9'h1FF.
- Last pixel 0x0F -> col_out = 24'h0F0B07, pe_en_ctrl = 9'h1FF, frame_done = 1 for exactly one cycle, busy = 0 in the same cycle, state IDLE.
- Drop pix_valid for 3 cycles before pixel (2, 1) -> col_out holds 24'h080400, pe_en_ctrl = 0 during the stall, then 24'h090501 with 9'h03F resumes; all later values are unchanged.
- Assert sof mid-row-3 with pixel 0x20 -> restart. The next col_valid appears only after 8 more accepted pixels, and no frame_done is issued for the aborted frame.
- Assert rst during row 2 -> all outputs are 0 on the next edge. A following frame with pixel(r, c) = 0x40 + 4r + c gives first column 24'h484440, with no stale line data.

Source files
------------

// File: rtl/cu_line_buffer_if.sv
// Pixel-in / column-out bundle between the raster source, the line buffer
// and the downstream convolution engine.
interface cu_line_buffer_if #(
    parameter int DATA_W = 8
);
    logic                  sof;
    logic                  pix_valid;
    logic [DATA_W-1:0]     pix_in;
    logic [3*DATA_W-1:0]   col_out;
    logic [8:0]            pe_en_ctrl;
    logic                  col_valid;
    logic                  win_valid;
    logic                  busy;
    logic                  frame_done;

    // Pixel source side: drives the stream, observes the column outputs.
    modport master (
        output sof,
        output pix_valid,
        output pix_in,
        input  col_out,
        input  pe_en_ctrl,
        input  col_valid,
        input  win_valid,
        input  busy,
        input  frame_done
    );

    // Line buffer side: consumes the stream, produces the column outputs.
    modport slave (
        input  sof,
        input  pix_valid,
        input  pix_in,
        output col_out,
        output pe_en_ctrl,
        output col_valid,
        output win_valid,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/cu_line_buffer.sv
// Two-line raster buffer feeding cu_engine. Every accepted pixel yields a
// registered vertical 3-pixel column {row r, row r-1, row r-2} plus the PE
// enable ramp, one cycle after the accepting edge.
module cu_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic             clk,
    input  logic             rst,
    cu_line_buffer_if.slave  lb
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    // Position of the pixel being accepted this cycle (a start pixel is (0,0)).
    logic            start;
    logic            accept;
    logic [CW-1:0]   acc_col;
    logic [RW-1:0]   acc_row;
    logic            col_last;

    // Registered output state.
    logic [8:0]      pe_en_q, pe_en_d;
    logic            col_valid_q, col_valid_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            col_clr_q;
    logic [DATA_W-1:0] pix_q;

    // Line memories: lb1 holds row r-1, lb2 holds row r-2. Never cleared;
    // FILL rewrites both before any column is flagged valid.
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb2_mem [IMG_W];
    logic [DATA_W-1:0] lb1_rd_q;
    logic [DATA_W-1:0] lb2_rd_q;

    // Enable ramp: lane gi (3 PEs each) is live once the column index has
    // reached gi, so the engine fills its window from the left edge.
    logic [2:0] lane_en;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_en[gi] = (acc_col >= CW'(gi));
        end
    endgenerate

    // Next-state, counter and output decode.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        pe_en_d      = '0;
        col_valid_d  = 1'b0;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        start    = lb.sof & lb.pix_valid;
        accept   = lb.pix_valid & (start | (state_q != IDLE));
        acc_col  = start ? '0 : col_q;
        acc_row  = start ? '0 : row_q;
        col_last = (acc_col == COL_LAST);

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = acc_row + ROW_ONE;
            end else begin
                col_d = acc_col + CW'(1);
                row_d = acc_row;
            end

            if (acc_row >= ROW_TWO) begin
                col_valid_d = 1'b1;
                win_valid_d = lane_en[2];
                pe_en_d     = {{3{lane_en[2]}}, {3{lane_en[1]}}, {3{lane_en[0]}}};
            end

            if (start) begin
                state_d = FILL;
            end else begin
                unique case (state_q)
                    FILL: begin
                        if (col_last && (acc_row == ROW_ONE)) begin
                            state_d = RUN;
                        end
                    end
                    RUN: begin
                        if (col_last && (acc_row == ROW_LAST)) begin
                            state_d      = IDLE;
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            pe_en_q      <= '0;
            col_valid_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            col_clr_q    <= 1'b1;
            pix_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pe_en_q      <= pe_en_d;
            col_valid_q  <= col_valid_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                col_clr_q <= 1'b0;
                pix_q     <= lb.pix_in;
            end
        end
    end

    // Read-before-write line memory shift; read data is registered so the
    // column lines up with the registered pixel.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb1_rd_q         <= lb1_mem[acc_col];
            lb2_rd_q         <= lb2_mem[acc_col];
            lb2_mem[acc_col] <= lb1_mem[acc_col];
            lb1_mem[acc_col] <= lb.pix_in;
        end
    end

    // The read registers carry no reset; the clear flag masks them to zero
    // until the first pixel after reset lands.
    assign lb.col_out    = col_clr_q ? '0 : {pix_q, lb1_rd_q, lb2_rd_q};
    assign lb.pe_en_ctrl = pe_en_q;
    assign lb.col_valid  = col_valid_q;
    assign lb.win_valid  = win_valid_q;
    assign lb.busy       = (state_q != IDLE);
    assign lb.frame_done = frame_done_q;

endmodule

// File: tb/tb_cu_line_buffer.sv
// Directed bench for cu_line_buffer with a 4x4 frame.
module tb_cu_line_buffer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cu_line_buffer_if #(.DATA_W(8)) bus ();

    cu_line_buffer #(
        .DATA_W (8),
        .IMG_W  (4),
        .IMG_H  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One input cycle: drive at negedge, sample 1 time unit after posedge.
    task automatic drive(input logic s, input logic v, input logic [7:0] p);
        @(negedge clk);
        bus.sof       = s;
        bus.pix_valid = v;
        bus.pix_in    = p;
        @(posedge clk);
        #1;
        $display("cyc sof=%0b v=%0b pix=%02h -> col_out=%06h pe=%03h cv=%0b wv=%0b busy=%0b fd=%0b",
                 s, v, p, bus.col_out, bus.pe_en_ctrl, bus.col_valid,
                 bus.win_valid, bus.busy, bus.frame_done);
    endtask

    // Full 4x4 frame, pixel = base + 4r + c, optional 3-cycle stall before
    // pixel index stall_before, optional trailing idle cycle.
    task automatic run_frame(input int base, input int stall_before, input bit trail_idle);
        logic [23:0] exp_col;
        logic [23:0] last_col;
        logic [8:0]  exp_pe;
        logic        exp_cv, exp_wv, exp_fd, exp_busy;
        int          idx;
        last_col = 24'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                idx = 4 * r + c;
                if (idx == stall_before) begin
                    for (int k = 0; k < 3; k++) begin
                        drive(1'b0, 1'b0, 8'hEE);
                        checks++;
                        if (bus.col_out !== last_col) begin
                            errors++;
                            $display("FAIL stall_hold col_out got=%06h exp=%06h", bus.col_out, last_col);
                        end
                        checks++;
                        if (bus.pe_en_ctrl !== 9'h000 || bus.col_valid !== 1'b0 || bus.win_valid !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_ctrl pe=%03h cv=%0b wv=%0b exp 000/0/0",
                                     bus.pe_en_ctrl, bus.col_valid, bus.win_valid);
                        end
                    end
                end
                drive(idx == 0, 1'b1, 8'(base + idx));
                exp_cv   = (r >= 2);
                exp_wv   = (r >= 2) && (c >= 2);
                exp_pe   = (r < 2) ? 9'h000 : (c == 0) ? 9'h007 : (c == 1) ? 9'h03F : 9'h1FF;
                exp_fd   = (idx == 15);
                exp_busy = (idx != 15);
                exp_col  = {8'(base + idx), 8'(base + idx - 4), 8'(base + idx - 8)};
                checks++;
                if (bus.col_valid !== exp_cv || bus.win_valid !== exp_wv) begin
                    errors++;
                    $display("FAIL valid r=%0d c=%0d cv=%0b wv=%0b exp cv=%0b wv=%0b",
                             r, c, bus.col_valid, bus.win_valid, exp_cv, exp_wv);
                end
                checks++;
                if (bus.pe_en_ctrl !== exp_pe) begin
                    errors++;
                    $display("FAIL pe_en r=%0d c=%0d got=%03h exp=%03h", r, c, bus.pe_en_ctrl, exp_pe);
                end
                checks++;
                if (bus.frame_done !== exp_fd || bus.busy !== exp_busy) begin
                    errors++;
                    $display("FAIL fd_busy r=%0d c=%0d fd=%0b busy=%0b exp fd=%0b busy=%0b",
                             r, c, bus.frame_done, bus.busy, exp_fd, exp_busy);
                end
                if (r >= 2) begin
                    checks++;
                    if (bus.col_out !== exp_col) begin
                        errors++;
                        $display("FAIL col_out r=%0d c=%0d got=%06h exp=%06h", r, c, bus.col_out, exp_col);
                    end
                    last_col = exp_col;
                end
            end
        end
        if (trail_idle) begin
            drive(1'b0, 1'b0, 8'h00);
            checks++;
            if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL after_frame fd=%0b busy=%0b exp 0/0", bus.frame_done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.sof       = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.col_out !== 24'h0 || bus.pe_en_ctrl !== 9'h0 || bus.col_valid !== 1'b0 ||
            bus.win_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset col_out=%06h pe=%03h cv=%0b wv=%0b busy=%0b fd=%0b exp all 0",
                     bus.col_out, bus.pe_en_ctrl, bus.col_valid, bus.win_valid, bus.busy, bus.frame_done);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        // pix_valid without sof in IDLE is ignored
        drive(1'b0, 1'b1, 8'h55);
        checks++;
        if (bus.busy !== 1'b0 || bus.col_out !== 24'h0) begin
            errors++;
            $display("FAIL idle_ignore busy=%0b col_out=%06h exp 0/000000", bus.busy, bus.col_out);
        end
    endtask

    task automatic test_full_frame();
        run_frame(0, -1, 1'b1);
    endtask

    task automatic test_stall();
        run_frame(0, 9, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h10, -1, 1'b0);
        run_frame(8'h30, -1, 1'b1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 14; i++) begin
            drive(i == 0, 1'b1, 8'(i));
        end
        // restart with 0x20 mid row 3; 8 fill pixels then first valid column
        for (int i = 0; i < 16; i++) begin
            drive(i == 0, 1'b1, 8'(8'h20 + i));
            if (i < 8) begin
                checks++;
                if (bus.col_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_fill i=%0d cv=%0b fd=%0b busy=%0b exp 0/0/1",
                             i, bus.col_valid, bus.frame_done, bus.busy);
                end
            end else if (i == 8) begin
                checks++;
                if (bus.col_valid !== 1'b1 || bus.col_out !== 24'h282420) begin
                    errors++;
                    $display("FAIL abort_first cv=%0b col_out=%06h exp 1/282420", bus.col_valid, bus.col_out);
                end
            end else if (i == 15) begin
                checks++;
                if (bus.frame_done !== 1'b1 || bus.col_out !== 24'h2F2B27) begin
                    errors++;
                    $display("FAIL abort_end fd=%0b col_out=%06h exp 1/2F2B27", bus.frame_done, bus.col_out);
                end
            end
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 1'b1, 8'(8'h90 + i));
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'h99;
        @(posedge clk);
        #1;
        checks++;
        if (bus.col_out !== 24'h0 || bus.pe_en_ctrl !== 9'h0 || bus.col_valid !== 1'b0 ||
            bus.win_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid col_out=%06h pe=%03h cv=%0b wv=%0b busy=%0b fd=%0b exp all 0",
                     bus.col_out, bus.pe_en_ctrl, bus.col_valid, bus.win_valid, bus.busy, bus.frame_done);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
        run_frame(8'h40, -1, 1'b1);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'h00;
        test_reset();
        test_full_frame();
        test_stall();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
